// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between the IF fetch port and the MEM data port, round-robin on conflict.
// Latency: grant is registered one cycle after IDLE samples a request; reads finish LAT+3 cycles IDLE-to-IDLE, writes 3.
// Backpressure: requesters hold req until their done pulse; stall_* tells the hazard logic a port is still waiting.
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        stall_if,
  output logic        stall_d,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Read wait counter start value; LAT is limited to 1..15 so it fits 4 bits.
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner;
  logic       last_grant;
  logic [3:0] cnt;

  logic       grant;
  logic       grant_d;
  logic       capture;
  logic       to_done;

  // Byte offset bits are dropped on purpose: memory is word addressed and
  // sub-word alignment is handled by the requesters.
  logic       unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Arbitration in IDLE: a lone requester wins, a conflict goes to the port not served last.
  always_comb begin
    grant   = 1'b0;
    grant_d = 1'b0;
    if (state == S_IDLE) begin
      grant   = if_req | d_req;
      grant_d = d_req & (~if_req | (last_grant == PORT_IF));
    end
  end

  // Next-state logic: writes skip the wait phase, reads count down the memory latency.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = (mem_we != 4'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Read data is valid exactly in the last counted WAIT cycle.
  assign capture = (state == S_WAIT) && (cnt == 4'd1);
  // Entering DONE is what raises the owner's done pulse for the following cycle.
  assign to_done = (state != S_DONE) && (state_nxt == S_DONE);

  // Control state: FSM, owning port, round-robin pointer and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= PORT_IF;
      last_grant <= PORT_IF;
      cnt        <= 4'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= grant_d;
        last_grant <= grant_d;
      end
      if ((state == S_ISSUE) && (mem_we == 4'd0)) begin
        cnt <= LAT_CNT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Memory request fields: loaded from the winner on grant, strobe/enables/data live only in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else if (grant) begin
      mem_req <= 1'b1;
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= {d_addr[31:2], 2'b00};
        mem_wdata <= d_wdata;
      end else begin
        mem_we    <= 4'd0;
        mem_addr  <= {if_addr[31:2], 2'b00};
        mem_wdata <= 32'd0;
      end
    end else begin
      // mem_addr deliberately holds its last value between accesses.
      mem_req   <= 1'b0;
      mem_we    <= 4'd0;
      mem_wdata <= 32'd0;
    end
  end

  // Completion: only the owner's done and read-data register ever change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      if_done <= to_done & (owner == PORT_IF);
      d_done  <= to_done & (owner == PORT_D);
      if (capture && (owner == PORT_IF)) begin
        if_rdata <= mem_rdata;
      end
      if (capture && (owner == PORT_D)) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  // Stalls drop in the done cycle so the pipeline advances together with the data.
  assign stall_if = if_req & ~if_done;
  assign stall_d  = d_req & ~d_done;

endmodule
